// File: rtl/axi4l_wr_master_p_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) between the write master and its slave.
interface axi4l_wr_master_p_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
);
   localparam int unsigned STRB_W = DATA_W / 8;

   logic [ADDR_W-1:0] aw_addr;
   logic [2:0]        aw_prot;
   logic              aw_valid;
   logic              aw_ready;
   logic [DATA_W-1:0] w_data;
   logic [STRB_W-1:0] w_strb;
   logic              w_valid;
   logic              w_ready;
   logic [1:0]        b_resp;
   logic              b_valid;
   logic              b_ready;

   modport master (
      output aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
      input  aw_ready, w_ready, b_resp, b_valid
   );

   modport slave (
      input  aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
      output aw_ready, w_ready, b_resp, b_valid
   );
endinterface

// File: rtl/axi4l_wr_master_p.sv
// Single-beat AXI4-Lite write master: one accepted start -> one AW/W/B exchange.
// Define AXI4L_WR_MASTER_TIMEOUT_EN to add the watchdog abort (TMO_W-bit counter).
module axi4l_wr_master_p #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned TMO_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   data,
   input  logic [DATA_W/8-1:0] strb,
   output logic                busy,
   output logic                done,
   output logic [1:0]          resp,
   output logic                err,
   output logic                timeout,
   axi4l_wr_master_p_if.master axi
);
   localparam int unsigned STRB_W = DATA_W / 8;

   if (DATA_W != 32 && DATA_W != 64) begin : g_chk_data_w
      $error("axi4l_wr_master_p: DATA_W must be 32 or 64");
   end
   if (TMO_W < 2) begin : g_chk_tmo_w
      $error("axi4l_wr_master_p: TMO_W must be at least 2");
   end

   typedef enum logic [1:0] {IDLE, XFER, RESP} state_e;

   state_e            state_q, state_d;
   logic              aw_valid_q, aw_valid_d;
   logic              w_valid_q, w_valid_d;
   logic              b_ready_q, b_ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [1:0]        resp_q, resp_d;
   logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
   logic [DATA_W-1:0] w_data_q, w_data_d;
   logic [STRB_W-1:0] w_strb_q, w_strb_d;

`ifdef AXI4L_WR_MASTER_TIMEOUT_EN
   // Expire on the edge where the count would reach 2^TMO_W-1.
   localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             timeout_q, timeout_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         b_ready_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         resp_q     <= 2'b00;
         aw_addr_q  <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
      end else begin
         state_q    <= state_d;
         aw_valid_q <= aw_valid_d;
         w_valid_q  <= w_valid_d;
         b_ready_q  <= b_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         resp_q     <= resp_d;
         aw_addr_q  <= aw_addr_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      aw_valid_d = aw_valid_q;
      w_valid_d  = w_valid_q;
      b_ready_d  = b_ready_q;
      done_d     = 1'b0;
      resp_d     = resp_q;
      aw_addr_d  = aw_addr_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
`ifdef AXI4L_WR_MASTER_TIMEOUT_EN
      tmo_cnt_d  = tmo_cnt_q;
      timeout_d  = timeout_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               aw_addr_d  = addr;
               w_data_d   = data;
               w_strb_d   = strb;
               aw_valid_d = 1'b1;
               w_valid_d  = 1'b1;
               state_d    = XFER;
`ifdef AXI4L_WR_MASTER_TIMEOUT_EN
               tmo_cnt_d  = '0;
`endif
            end
         end
         XFER: begin
            // Each channel retires on its own handshake and never re-asserts.
            aw_valid_d = aw_valid_q & ~axi.aw_ready;
            w_valid_d  = w_valid_q & ~axi.w_ready;
            if (!aw_valid_d && !w_valid_d) begin
               state_d   = RESP;
               b_ready_d = 1'b1;
            end
         end
         RESP: begin
            if (axi.b_valid && b_ready_q) begin
               resp_d    = axi.b_resp;
               b_ready_d = 1'b0;
               done_d    = 1'b1;
               state_d   = IDLE;
`ifdef AXI4L_WR_MASTER_TIMEOUT_EN
               timeout_d = 1'b0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef AXI4L_WR_MASTER_TIMEOUT_EN
      // Watchdog abort; a B handshake on the expiry edge completes normally instead.
      if (state_q != IDLE) begin
         tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
         if (tmo_cnt_q == TMO_LAST && !(state_q == RESP && axi.b_valid && b_ready_q)) begin
            aw_valid_d = 1'b0;
            w_valid_d  = 1'b0;
            b_ready_d  = 1'b0;
            done_d     = 1'b1;
            resp_d     = 2'b10;
            timeout_d  = 1'b1;
            state_d    = IDLE;
         end
      end
`endif

      busy_d = (state_d != IDLE);
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign resp         = resp_q;
   assign err          = resp_q[1];
   assign axi.aw_addr  = aw_addr_q;
   assign axi.aw_prot  = 3'b000;
   assign axi.aw_valid = aw_valid_q;
   assign axi.w_data   = w_data_q;
   assign axi.w_strb   = w_strb_q;
   assign axi.w_valid  = w_valid_q;
   assign axi.b_ready  = b_ready_q;
endmodule

// File: tb/tb_axi4l_wr_master_p.sv
// Self-checking bench for axi4l_wr_master_p: directed scenarios plus randomized handshake delays
// against a cycle-arithmetic model; follows AXI4L_WR_MASTER_TIMEOUT_EN if defined.
module tb_axi4l_wr_master_p;
   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned TMO_W  = 4;
   localparam int          BOUND  = 60;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   logic [STRB_W-1:0] strb;
   logic              busy, done, err, timeout;
   logic [1:0]        resp;

   int n_chk  = 0;
   int n_fail = 0;

   axi4l_wr_master_p_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

   axi4l_wr_master_p #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_W(TMO_W)) dut (
      .clk(clk), .rst(rst), .start(start), .addr(addr), .data(data), .strb(strb),
      .busy(busy), .done(done), .resp(resp), .err(err), .timeout(timeout), .axi(axi)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got=running required=finished");
      $fatal(1, "watchdog");
   end

   // Observations of one transaction; times are negedge indices after the start cycle (t=0).
   typedef struct {
      int         t_r, t_d, aw_first, aw_cyc, w_cyc, bad_pay, bad_busy;
      logic [1:0] resp;
      logic       err, tmo, busy_at_done, aw_at_done;
   } obs_t;

   typedef struct { int t_r, t_d, aw_cyc, w_cyc; } exp_t;

   // Reference timing: valids rise at t=1, each channel retires after its ready delay,
   // b_ready rises the cycle after the later handshake, done follows the B handshake.
   function automatic exp_t model(input int aw_dly, input int w_dly, input int b_t);
      exp_t e;
      int   last_hs;
      last_hs  = ((aw_dly > w_dly) ? aw_dly : w_dly) + 1;
      e.t_r    = last_hs + 1;
      e.t_d    = ((b_t > e.t_r) ? b_t : e.t_r) + 1;
      e.aw_cyc = aw_dly + 1;
      e.w_cyc  = w_dly + 1;
      return e;
   endfunction

   // Slave/driver for one transaction; called at a negedge with the DUT idle.
   task automatic drv(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic [STRB_W-1:0] s, input int aw_dly, input int w_dly,
                      input int b_t, input logic [1:0] br, input bit hold, output obs_t o);
      bit aw_done = 0, w_done = 0, b_done = 0;
      o.t_r = -1; o.t_d = -1; o.aw_first = -1; o.aw_cyc = 0; o.w_cyc = 0;
      o.bad_pay = 0; o.bad_busy = 0; o.resp = 2'bxx; o.err = 1'bx; o.tmo = 1'bx;
      o.busy_at_done = 1'bx; o.aw_at_done = 1'bx;
      start = 1'b1; addr = a; data = d; strb = s;
      axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.b_valid = 1'b0; axi.b_resp = br;
      for (int t = 1; t <= BOUND; t++) begin
         @(negedge clk);
         start = hold;
         addr  = {$urandom, $urandom};
         data  = {$urandom, $urandom};
         strb  = STRB_W'($urandom);
         if (done) begin
            o.t_d = t; o.resp = resp; o.err = err; o.tmo = timeout;
            o.busy_at_done = busy; o.aw_at_done = axi.aw_valid;
            break;
         end
         if (!busy) o.bad_busy++;
         if (axi.aw_valid) begin
            o.aw_cyc++;
            if (o.aw_first < 0) o.aw_first = t;
            if (axi.aw_addr !== a || axi.aw_prot !== 3'b000) o.bad_pay++;
         end
         if (axi.w_valid) begin
            o.w_cyc++;
            if (axi.w_data !== d || axi.w_strb !== s) o.bad_pay++;
         end
         if (axi.b_ready && o.t_r < 0) o.t_r = t;
         axi.aw_ready = (t >= 1 + aw_dly) && !aw_done;
         axi.w_ready  = (t >= 1 + w_dly) && !w_done;
         axi.b_valid  = (t >= b_t) && !b_done;
         if (axi.aw_valid && axi.aw_ready) aw_done = 1;
         if (axi.w_valid && axi.w_ready) w_done = 1;
         if (axi.b_valid && axi.b_ready) b_done = 1;
      end
      axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.b_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; addr = '1; data = '1; strb = '1;
      axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.b_valid = 1'b0; axi.b_resp = 2'b11;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({axi.aw_valid, axi.w_valid, axi.b_ready, busy, done, err, timeout} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_flags got=%b required=0000000",
                  {axi.aw_valid, axi.w_valid, axi.b_ready, busy, done, err, timeout});
      end
      n_chk++;
      if (resp !== 2'b00) begin n_fail++; $display("FAIL reset_resp got=%0d required=0", resp); end
      n_chk++;
      if (axi.aw_addr !== '0 || axi.aw_prot !== 3'b000) begin
         n_fail++; $display("FAIL reset_aw_addr got=%h required=0", axi.aw_addr);
      end
      n_chk++;
      if (axi.w_data !== '0 || axi.w_strb !== '0) begin
         n_fail++; $display("FAIL reset_w_payload got=%h/%h required=0/0", axi.w_data, axi.w_strb);
      end
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || axi.aw_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_no_start got busy=%b aw_valid=%b required=0/0", busy, axi.aw_valid);
      end
   endtask

   task automatic test_single();
      obs_t o;
      drv(64'h8000_0010, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0, 0, 2, 2'b00, 0, o);
      start = 1'b0;
      n_chk++;
      if (o.aw_cyc !== 1 || o.w_cyc !== 1) begin
         n_fail++; $display("FAIL single_valid_cycles got=%0d/%0d required=1/1", o.aw_cyc, o.w_cyc);
      end
      n_chk++;
      if (o.t_d !== 3) begin n_fail++; $display("FAIL single_done_cycle got=%0d required=3", o.t_d); end
      n_chk++;
      if (o.resp !== 2'b00 || o.err !== 1'b0 || o.tmo !== 1'b0) begin
         n_fail++; $display("FAIL single_resp got=%0d/%b/%b required=0/0/0", o.resp, o.err, o.tmo);
      end
      n_chk++;
      if (o.bad_pay !== 0 || o.busy_at_done !== 1'b0) begin
         n_fail++; $display("FAIL single_payload_busy got=%0d/%b required=0/0", o.bad_pay, o.busy_at_done);
      end
      @(negedge clk);
      n_chk++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_width got=%b required=0", done); end
   endtask

   task automatic test_aw_delay();
      obs_t o;
      exp_t e;
      e = model(4, 0, 2);
      drv({$urandom, $urandom}, {$urandom, $urandom}, STRB_W'($urandom), 4, 0, 2, 2'b01, 0, o);
      start = 1'b0;
      n_chk++;
      if (o.w_cyc !== 1 || o.aw_cyc !== 5) begin
         n_fail++; $display("FAIL awdly_valid_cycles got=%0d/%0d required=5/1", o.aw_cyc, o.w_cyc);
      end
      n_chk++;
      if (o.bad_pay !== 0) begin n_fail++; $display("FAIL awdly_stable got=%0d required=0", o.bad_pay); end
      n_chk++;
      if (o.t_r !== e.t_r) begin n_fail++; $display("FAIL awdly_bready got=%0d required=%0d", o.t_r, e.t_r); end
      n_chk++;
      if (o.t_d !== e.t_d || o.resp !== 2'b01) begin
         n_fail++; $display("FAIL awdly_done got=%0d/%0d required=%0d/1", o.t_d, o.resp, e.t_d);
      end
   endtask

   task automatic test_err_resp();
      obs_t o;
      int   bad = 0;
      drv({$urandom, $urandom}, {$urandom, $urandom}, STRB_W'($urandom), 0, 1, 3, 2'b10, 0, o);
      start = 1'b0;
      n_chk++;
      if (o.resp !== 2'b10 || o.err !== 1'b1) begin
         n_fail++; $display("FAIL err_done got=%0d/%b required=2/1", o.resp, o.err);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (resp !== 2'b10 || err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) bad++;
      end
      n_chk++;
      if (bad !== 0) begin n_fail++; $display("FAIL err_hold got=%0d bad cycles required=0", bad); end
   endtask

   task automatic test_back_to_back();
      obs_t       o;
      logic [1:0] brs [3] = '{2'b00, 2'b01, 2'b11};
      for (int k = 0; k < 3; k++) begin
         drv({$urandom, $urandom}, {$urandom, $urandom}, STRB_W'($urandom), 0, 0, 2, brs[k], 1, o);
         n_chk++;
         if (o.aw_first !== 1 || o.t_d !== 3) begin
            n_fail++; $display("FAIL b2b_timing[%0d] got=%0d/%0d required=1/3", k, o.aw_first, o.t_d);
         end
         n_chk++;
         if (o.aw_at_done !== 1'b0 || o.bad_pay !== 0 || o.bad_busy !== 0) begin
            n_fail++; $display("FAIL b2b_gap_payload[%0d] got=%b/%0d/%0d required=0/0/0",
                               k, o.aw_at_done, o.bad_pay, o.bad_busy);
         end
         n_chk++;
         if (o.resp !== brs[k] || o.err !== brs[k][1]) begin
            n_fail++; $display("FAIL b2b_resp[%0d] got=%0d/%b required=%0d/%b", k, o.resp, o.err, brs[k], brs[k][1]);
         end
      end
      start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_in_resp();
      obs_t o;
      exp_t e;
      start = 1'b1; addr = {$urandom, $urandom}; data = {$urandom, $urandom}; strb = STRB_W'($urandom);
      @(negedge clk);
      start = 1'b0; axi.aw_ready = 1'b1; axi.w_ready = 1'b1;
      @(negedge clk);
      axi.aw_ready = 1'b0; axi.w_ready = 1'b0;
      n_chk++;
      if (axi.b_ready !== 1'b1) begin n_fail++; $display("FAIL rst_resp_entry got=%b required=1", axi.b_ready); end
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      n_chk++;
      if ({axi.b_ready, busy, done, axi.aw_valid, axi.w_valid} !== 5'b0) begin
         n_fail++; $display("FAIL rst_resp_abort got=%b required=00000",
                            {axi.b_ready, busy, done, axi.aw_valid, axi.w_valid});
      end
      n_chk++;
      if (resp !== 2'b00 || axi.aw_addr !== '0) begin
         n_fail++; $display("FAIL rst_resp_clear got=%0d/%h required=0/0", resp, axi.aw_addr);
      end
      @(negedge clk);
      n_chk++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rst_resp_no_done got=%b/%b required=0/0", done, busy);
      end
      e = model(2, 1, 1);
      drv({$urandom, $urandom}, {$urandom, $urandom}, STRB_W'($urandom), 2, 1, 1, 2'b11, 0, o);
      start = 1'b0;
      n_chk++;
      if (o.t_d !== e.t_d || o.resp !== 2'b11 || o.bad_pay !== 0) begin
         n_fail++; $display("FAIL rst_resp_recover got=%0d/%0d/%0d required=%0d/3/0", o.t_d, o.resp, o.bad_pay, e.t_d);
      end
   endtask

   task automatic test_timeout();
      int         t_done = -1, extra = 0;
      logic [1:0] r = 2'bxx;
      logic       e = 1'bx, to = 1'bx, bz = 1'bx, brdy = 1'bx;
      start = 1'b1; addr = {$urandom, $urandom}; data = {$urandom, $urandom}; strb = STRB_W'($urandom);
      for (int t = 1; t <= 40; t++) begin
         @(negedge clk);
         start = 1'b0;
         axi.aw_ready = (t == 1); axi.w_ready = (t == 1); axi.b_valid = 1'b0;
         if (done && t_done < 0) begin
            t_done = t; r = resp; e = err; to = timeout; bz = busy; brdy = axi.b_ready;
         end else if (done) extra++;
      end
      axi.aw_ready = 1'b0; axi.w_ready = 1'b0;
`ifdef AXI4L_WR_MASTER_TIMEOUT_EN
      n_chk++;
      if (t_done !== (1 << TMO_W)) begin
         n_fail++; $display("FAIL tmo_done_cycle got=%0d required=%0d", t_done, 1 << TMO_W);
      end
      n_chk++;
      if (to !== 1'b1 || r !== 2'b10 || e !== 1'b1) begin
         n_fail++; $display("FAIL tmo_status got=%b/%0d/%b required=1/2/1", to, r, e);
      end
      n_chk++;
      if (bz !== 1'b0 || brdy !== 1'b0 || extra !== 0) begin
         n_fail++; $display("FAIL tmo_release got=%b/%b/%0d required=0/0/0", bz, brdy, extra);
      end
      n_chk++;
      if (timeout !== 1'b1 || resp !== 2'b10) begin
         n_fail++; $display("FAIL tmo_hold got=%b/%0d required=1/2", timeout, resp);
      end
`else
      n_chk++;
      if (t_done !== -1 || extra !== 0) begin
         n_fail++; $display("FAIL notmo_no_done got=%0d required=-1", t_done);
      end
      n_chk++;
      if (busy !== 1'b1 || axi.b_ready !== 1'b1 || timeout !== 1'b0) begin
         n_fail++; $display("FAIL notmo_waiting got=%b/%b/%b required=1/1/0", busy, axi.b_ready, timeout);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_chk++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL notmo_reset got=%b required=0", busy); end
`endif
   endtask

   task automatic test_random();
      obs_t       o;
      exp_t       e;
      int         aw_dly, w_dly, b_t;
      logic [1:0] br;
      for (int k = 0; k < 40; k++) begin
         aw_dly = $urandom_range(0, 4); w_dly = $urandom_range(0, 4);
         b_t = $urandom_range(1, 8); br = 2'($urandom);
         e = model(aw_dly, w_dly, b_t);
         drv({$urandom, $urandom}, {$urandom, $urandom}, STRB_W'($urandom), aw_dly, w_dly, b_t, br,
             1'($urandom), o);
         if ($urandom_range(0, 1) == 0) start = 1'b0;
         n_chk++;
         if (o.t_d !== e.t_d || o.t_r !== e.t_r) begin
            n_fail++; $display("FAIL rnd_timing[%0d] got=%0d/%0d required=%0d/%0d", k, o.t_r, o.t_d, e.t_r, e.t_d);
         end
         n_chk++;
         if (o.aw_cyc !== e.aw_cyc || o.w_cyc !== e.w_cyc) begin
            n_fail++; $display("FAIL rnd_valids[%0d] got=%0d/%0d required=%0d/%0d",
                               k, o.aw_cyc, o.w_cyc, e.aw_cyc, e.w_cyc);
         end
         n_chk++;
         if (o.bad_pay !== 0 || o.bad_busy !== 0 || o.busy_at_done !== 1'b0) begin
            n_fail++; $display("FAIL rnd_payload[%0d] got=%0d/%0d/%b required=0/0/0",
                               k, o.bad_pay, o.bad_busy, o.busy_at_done);
         end
         n_chk++;
         if (o.resp !== br || o.err !== br[1] || o.tmo !== 1'b0) begin
            n_fail++; $display("FAIL rnd_resp[%0d] got=%0d/%b/%b required=%0d/%b/0", k, o.resp, o.err, o.tmo, br, br[1]);
         end
         if (start == 1'b0) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      start = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_aw_delay();
      test_err_resp();
      test_back_to_back();
      test_reset_in_resp();
      test_timeout();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/axi4l_wr_master_p.md
AXI4L_WR_MASTER_P -- requirements
Module: axi4l_wr_master_p

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; multiple of 8, 32 or 64 only.
- TMO_W, 8, timeout counter width; used only with the timeout feature.
- STRB_W = DATA_W/8, derived, not overridable.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock; all logic on its rising edge.
- rst, in, 1, reset; synchronous, active-high.
- start, in, 1, request a write; sampled in IDLE only.
- addr, in, ADDR_W, write address; captured when start is accepted.
- data, in, DATA_W, write data; captured when start is accepted.
- strb, in, STRB_W, byte enables; captured when start is accepted.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle completion pulse.
- resp, out, 2, last BRESP, or the forced timeout code.
- err, out, 1, equals resp[1]; valid while done is high and held until the next done.
- timeout, out, 1, high together with done when the transaction was aborted.
- aw_addr, out, ADDR_W, write address channel address.
- aw_prot, out, 3, constant 3'b000.
- aw_valid, out, 1, write address channel valid.
- aw_ready, in, 1, write address channel ready.
- w_data, out, DATA_W, write data channel data.
- w_strb, out, STRB_W, write data channel byte strobes.
- w_valid, out, 1, write data channel valid.
- w_ready, in, 1, write data channel ready.
- b_resp, in, 2, write response code.
- b_valid, in, 1, write response valid.
- b_ready, out, 1, write response ready.

Function
REQ-003 The block SHALL implement three states: IDLE, XFER and RESP.
REQ-004 In IDLE with start=1, the block SHALL latch addr, data and strb into aw_addr, w_data and w_strb, and in the next cycle assert aw_valid=1, w_valid=1, busy=1 and enter XFER. Start-to-valid latency is 1 cycle.
REQ-005 The block SHALL drive the AW and W channels concurrently. Each channel's valid SHALL clear on the edge where valid&ready=1 for that channel, independently of the other channel, and SHALL never re-assert within the same transaction.
REQ-006 While a valid is high, the block SHALL hold its payload stable and SHALL NOT drop the valid before its handshake.
REQ-007 When both handshakes are complete, the block SHALL enter RESP with b_ready=1; this includes both completing on the same edge.
REQ-008 b_ready SHALL be 0 in IDLE and XFER. A b_valid arriving during XFER SHALL be held off until RESP.
REQ-009 On the edge where b_valid&b_ready=1 in RESP, the block SHALL:
- capture b_resp into resp;
- clear b_ready;
- return to IDLE;
- assert done=1 for exactly the following cycle, with busy=0 in that cycle.
REQ-010 The block SHALL accept start in the same cycle that done is high, giving back-to-back transactions with 1 idle cycle between a B handshake and the next AW/W valid.
REQ-011 The block SHALL ignore start while busy=1. Captured payload SHALL NOT change mid-transaction.
REQ-012 resp, err and timeout SHALL hold their values until the next done pulse.

Reset
REQ-013 When rst=1 at a clock edge, the block SHALL enter IDLE and force these registered outputs to 0 in the following cycle: aw_valid, w_valid, b_ready, busy, done, resp, timeout, aw_addr, w_data, w_strb. err follows resp and is therefore 0.
REQ-014 Reset mid-transaction SHALL abandon the transaction immediately, with no done pulse. rst takes priority over start on the same edge.

Configuration
REQ-015 With macro AXI4L_WR_MASTER_TIMEOUT_EN defined, the block SHALL implement the timeout feature:
- A TMO_W-bit counter clears on start acceptance and increments each cycle in XFER and RESP.
- On reaching 2^TMO_W-1 before the B handshake, the block SHALL clear all valids and b_ready, return to IDLE, and pulse done with timeout=1 and resp=2'b10 (so err=1).
- A B handshake on the same edge as expiry SHALL take priority and complete normally with timeout=0.
REQ-016 With AXI4L_WR_MASTER_TIMEOUT_EN undefined, the block SHALL contain no counter, SHALL wait indefinitely in XFER and RESP, and SHALL tie timeout to 0.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Single write, addr=0x8000_0010, data=0xDEAD_BEEF_0123_4567, strb=0xFF, aw_ready=w_ready=1, b_valid one cycle after both handshakes, b_resp=0 -> both valids high for 1 cycle; done pulses 3 cycles after the start cycle; resp=0, err=0.
- aw_ready delayed 4 cycles, w_ready=1 -> w_valid drops after 1 cycle; aw_valid held with a stable aw_addr for 5 cycles; b_ready rises only after the AW handshake.
- b_resp=2'b10 -> done pulse with err=1 and resp=2'b10, held through 10 idle cycles.
- Start held high continuously across 3 transactions -> 3 done pulses, each followed by exactly 1 gap cycle before the next AW valid; payload changes during busy are ignored.
- rst asserted while in RESP -> next cycle b_ready=0, busy=0, no done pulse; a following start operates normally.
- With AXI4L_WR_MASTER_TIMEOUT_EN defined, TMO_W=4, b_valid never asserted -> done with timeout=1 and resp=2'b10 on the cycle after 15 counted cycles; with the macro undefined, the block stays in RESP indefinitely.
